hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 80 ++++++++
 tb/tb_hazard_scoreboard.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes to drive forwarding selects, load-use stalls and redirect flushes.
// Define HAZARD_FWD_EN to enable operand forwarding; without it any in-flight match stalls until retirement.
module hazard_scoreboard #(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int DEPTH               = 3,
    parameter int LOAD_STAGE          = 2,
    parameter int CNT_BITS            = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dec_valid,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_sr1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_sr2,
    input  logic                           dec_sr1_used,
    input  logic                           dec_sr2_used,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_dr,
    input  logic                           dec_regWrite,
    input  logic                           dec_isLoad,
    input  logic                           redirect,
    output logic                           stall,
    output logic                           flush,
    output logic                           issue,
    output logic [DEPTH-1:0]               fwd_sel1,
    output logic [DEPTH-1:0]               fwd_sel2,
    output logic [CNT_BITS-1:0]            stall_count,
    output logic [CNT_BITS-1:0]            flush_count
);
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    logic [DEPTH-1:0]                          v, w, ld, avail;
    logic [DEPTH-1:0][REG_INDEX_BIT_WIDTH-1:0] dr;
    logic [1:0][REG_INDEX_BIT_WIDTH-1:0]       src;
    logic [1:0]                                used, hz;
    logic [1:0][DEPTH-1:0]                     sel;

    assign src  = {dec_sr2, dec_sr1};
    assign used = {dec_sr2_used, dec_sr1_used};

    always_comb begin
        avail = '0;
        for (int s = 0; s < DEPTH; s++)
            avail[s] = FWD && (!ld[s] || s + 1 >= LOAD_STAGE);
    end

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        sel = '0;
        hz  = '0;
        for (int i = 0; i < 2; i++)
            for (int s = DEPTH - 1; s >= 0; s--)
                if (v[s] && w[s] && used[i] && dr[s] == src[i]) begin
                    sel[i]    = '0;
                    sel[i][s] = avail[s];
                    hz[i]     = !avail[s];
                end
    end

    assign fwd_sel1 = sel[0];
    assign fwd_sel2 = sel[1];
    assign stall    = (|hz) && dec_valid && !redirect;
    assign flush    = redirect && dec_valid;
    assign issue    = dec_valid && !stall && !redirect && !reset;

    always_ff @(posedge clk) begin
        v  <= reset ? '0 : {v[DEPTH-2:0], issue};
        w  <= {w[DEPTH-2:0], dec_regWrite};
        ld <= {ld[DEPTH-2:0], dec_isLoad};
        dr <= {dr[DEPTH-2:0], dec_dr};
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
            if (flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks of hazard_scoreboard against a stage-list reference model.
module tb_hazard_scoreboard;
    localparam int W  = 4;
    localparam int D  = 3;
    localparam int LS = 2;
    localparam int CB = 16;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int NO = 3 + 2 * D;

    logic clk = 0, reset = 1;
    logic dv = 0, u1 = 0, u2 = 0, rw = 0, ldi = 0, redir = 0;
    logic [W-1:0] sr1 = 0, sr2 = 0, ddr = 0;
    logic stall, flush, issue;
    logic [D-1:0] fwd_sel1, fwd_sel2;
    logic [CB-1:0] stall_count, flush_count;

    int checks = 0, failures = 0;

    bit          m_v  [1:D];
    bit          m_w  [1:D];
    bit          m_ld [1:D];
    bit [W-1:0]  m_dr [1:D];
    int sc = 0, fc = 0;
    localparam int SMAX = (1 << CB) - 1;

    hazard_scoreboard #(.REG_INDEX_BIT_WIDTH(W), .DEPTH(D), .LOAD_STAGE(LS), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset), .dec_valid(dv), .dec_sr1(sr1), .dec_sr2(sr2),
        .dec_sr1_used(u1), .dec_sr2_used(u2), .dec_dr(ddr), .dec_regWrite(rw),
        .dec_isLoad(ldi), .redirect(redir), .stall(stall), .flush(flush), .issue(issue),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // First (youngest) in-flight writer of r decides: forward if its data is ready, else hazard.
    function automatic logic [D-1:0] src_sel(input logic [W-1:0] r, input logic u, output logic hz);
        src_sel = '0;
        hz = 0;
        for (int s = 1; s <= D; s++)
            if (u && m_v[s] && m_w[s] && m_dr[s] == r) begin
                if (FWD && (!m_ld[s] || s >= LS)) src_sel = D'(1) << (s - 1);
                else hz = 1;
                break;
            end
    endfunction

    function automatic logic [NO-1:0] exp_outs();
        logic h1, h2, st, fl, is;
        logic [D-1:0] s1, s2;
        s1 = src_sel(sr1, u1, h1);
        s2 = src_sel(sr2, u2, h2);
        st = (h1 | h2) & dv & ~redir;
        fl = redir & dv;
        is = dv & ~st & ~redir & ~reset;
        return {st, fl, is, s1, s2};
    endfunction

    task automatic drive(input logic v, input int a, input logic ua, input int b, input logic ub,
                         input int d, input logic w, input logic l, input logic r);
        dv = v; sr1 = W'(a); u1 = ua; sr2 = W'(b); u2 = ub; ddr = W'(d); rw = w; ldi = l; redir = r;
    endtask

    task automatic tick();
        logic [NO-1:0] e;
        e = exp_outs();
        @(posedge clk);
        if (reset) begin
            for (int s = 1; s <= D; s++) m_v[s] = 0;
            sc = 0; fc = 0;
        end else begin
            for (int s = D; s >= 2; s--) begin
                m_v[s] = m_v[s-1]; m_w[s] = m_w[s-1]; m_ld[s] = m_ld[s-1]; m_dr[s] = m_dr[s-1];
            end
            m_v[1] = e[2*D]; m_w[1] = rw; m_ld[1] = ldi; m_dr[1] = ddr;
            if (e[2*D+2] && sc < SMAX) sc++;
            if (e[2*D+1] && fc < SMAX) fc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        tick();
        #1;
        checks++;
        if (issue !== 1'b0) begin failures++; $display("FAIL reset_issue got=%b exp=0", issue); end
        checks++;
        if ({stall, flush, fwd_sel1, fwd_sel2, stall_count, flush_count} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b%b %b %b %0d %0d exp=all zero", stall, flush, fwd_sel1, fwd_sel2, stall_count, flush_count);
        end
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({stall, flush, issue, fwd_sel1, fwd_sel2} !== exp_outs()) begin
            failures++; $display("FAIL post_reset got=%b exp=%b", {stall, flush, issue, fwd_sel1, fwd_sel2}, exp_outs());
        end
        tick();
    endtask

    task automatic test_alu_dep();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        #1 tick();
        drive(1, 5, 1, 9, 0, 6, 1, 0, 0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({stall, flush, issue, fwd_sel1, fwd_sel2} !== exp_outs()) begin
                failures++; $display("FAIL alu_dep c=%0d got=%b exp=%b", c, {stall, flush, issue, fwd_sel1, fwd_sel2}, exp_outs());
            end
            if (c == 0 && FWD) begin
                checks++;
                if (fwd_sel1 !== 3'b001) begin failures++; $display("FAIL alu_sel_s1 got=%b exp=001", fwd_sel1); end
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < D; c++) tick();
    endtask

    task automatic test_load_use();
        int n = 0;
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
        #1 tick();
        drive(1, 1, 0, 3, 1, 8, 1, 0, 0);
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if ({stall, flush, issue, fwd_sel1, fwd_sel2} !== exp_outs()) begin
                failures++; $display("FAIL load_use c=%0d got=%b exp=%b", c, {stall, flush, issue, fwd_sel1, fwd_sel2}, exp_outs());
            end
            if (stall === 1'b1) n++;
            if (issue === 1'b1) break;
            tick();
        end
        checks++;
        if (n != (FWD ? 1 : D)) begin failures++; $display("FAIL load_use_len got=%0d exp=%0d", n, FWD ? 1 : D); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < D; c++) tick();
        #1;
        checks++;
        if ({stall_count, flush_count} !== {CB'(sc), CB'(fc)}) begin
            failures++; $display("FAIL load_use_cnt got=%0d/%0d exp=%0d/%0d", stall_count, flush_count, sc, fc);
        end
    endtask

    task automatic test_youngest();
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
            #1 tick();
            drive(1, 0, 0, 0, 0, 7, 1, logic'(k), 0);
            #1 tick();
            drive(1, 7, 1, 7, 1, 2, 0, 0, 0);
            #1;
            checks++;
            if ({stall, flush, issue, fwd_sel1, fwd_sel2} !== exp_outs()) begin
                failures++; $display("FAIL youngest k=%0d got=%b exp=%b", k, {stall, flush, issue, fwd_sel1, fwd_sel2}, exp_outs());
            end
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < D + 1; c++) tick();
        end
    endtask

    task automatic test_redirect();
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
        #1 tick();
        drive(1, 0, 0, 3, 1, 4, 1, 0, 1);
        #1;
        checks++;
        if ({stall, flush, issue} !== 3'b010) begin failures++; $display("FAIL redirect_outs got=%b exp=010", {stall, flush, issue}); end
        tick();
        drive(1, 4, 1, 3, 1, 0, 0, 0, 0);
        #1;
        checks++;
        if ({stall, flush, issue, fwd_sel1, fwd_sel2} !== exp_outs()) begin
            failures++; $display("FAIL redirect_bubble got=%b exp=%b", {stall, flush, issue, fwd_sel1, fwd_sel2}, exp_outs());
        end
        checks++;
        if (flush_count !== CB'(fc)) begin failures++; $display("FAIL redirect_cnt got=%0d exp=%0d", flush_count, fc); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < D; c++) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 63) == 0);
            #1;
            checks++;
            if ({stall, flush, issue, fwd_sel1, fwd_sel2} !== exp_outs()) begin
                failures++; $display("FAIL random c=%0d got=%b exp=%b", c, {stall, flush, issue, fwd_sel1, fwd_sel2}, exp_outs());
            end
            tick();
            checks++;
            if ({stall_count, flush_count} !== {CB'(sc), CB'(fc)}) begin
                failures++; $display("FAIL random_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, stall_count, flush_count, sc, fc);
            end
        end
        reset = 0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < D; c++) begin
            drive(1, 0, 0, 0, 0, 9, 1, 1, 0);
            #1 tick();
        end
        drive(1, 9, 1, 9, 1, 1, 1, 0, 0);
        reset = 1;
        #1 tick();
        reset = 0;
        #1;
        checks++;
        if ({stall, flush, fwd_sel1, fwd_sel2, stall_count, flush_count} !== '0 || issue !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got=%b%b%b %b %b %0d %0d exp=001 0 0 0 0", stall, flush, issue, fwd_sel1, fwd_sel2, stall_count, flush_count);
        end
        tick();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_alu_dep();
        test_load_use();
        test_youngest();
        test_redirect();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
